// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for a 16-bit async SRAM with configurable read latency,
// saturating access counters and a sticky WE/OE overlap flag.
module sram_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int READ_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [15:0]      SRAM_DQ,
    input  logic [17:0]      SRAM_ADDR,
    input  logic             SRAM_UB_N,
    input  logic             SRAM_LB_N,
    input  logic             SRAM_WE_N,
    input  logic             SRAM_CE_N,
    input  logic             SRAM_OE_N,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             proto_err
);
    logic [15:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] addr;
    logic                  wr_c, rd_c, drive;
    logic [READ_LAT-1:0]   pv, pub, plb;
    logic [15:0]           pd [READ_LAT];

    assign addr = SRAM_ADDR[DEPTH_LOG2-1:0];
    assign wr_c = !SRAM_CE_N && !SRAM_WE_N;
    assign rd_c = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

    // high address bits are deliberately ignored so the array aliases
    generate
        if (DEPTH_LOG2 < 18) begin : g_alias
            logic addr_unused;
            assign addr_unused = ^SRAM_ADDR[17:DEPTH_LOG2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_c && !SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
        if (wr_c && !SRAM_LB_N) mem[addr][7:0] <= SRAM_DQ[7:0];
    end

    always_ff @(posedge clk) begin
        pd[0]  <= mem[addr];
        pub[0] <= SRAM_UB_N;
        plb[0] <= SRAM_LB_N;
        for (int i = 1; i < READ_LAT; i++) begin
            pd[i]  <= pd[i-1];
            pub[i] <= pub[i-1];
            plb[i] <= plb[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv        <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            pv[0] <= rd_c;
            for (int i = 1; i < READ_LAT; i++) pv[i] <= pv[i-1];
            if (rd_c && rd_count != '1) rd_count <= rd_count + 1'b1;
            if (wr_c && wr_count != '1) wr_count <= wr_count + 1'b1;
            if (!SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N) proto_err <= 1'b1;
        end
    end

    // bus release is combinational on reset, CE_N or OE_N
    assign drive         = rst && rd_c && pv[READ_LAT-1];
    assign SRAM_DQ[15:8] = (drive && !pub[READ_LAT-1]) ? pd[READ_LAT-1][15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drive && !plb[READ_LAT-1]) ? pd[READ_LAT-1][7:0] : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized + directed scoreboard bench; undriven DQ lanes read as 8'hFF via pullups.
module tb_sram_responder;
    localparam int DL = 12;
    localparam int L  = 2;
    localparam int CW = 4;

    logic          clk = 0, rst = 0;
    logic          ce_n = 1, we_n = 1, oe_n = 1, ub_n = 1, lb_n = 1;
    logic [17:0]   addr = '0;
    logic [15:0]   tb_d = '0;
    logic          tb_drv = 0;
    wire  [15:0]   dq;
    logic [CW-1:0] rd_count, wr_count;
    logic          proto_err;

    always #5 clk = ~clk;
    assign dq = tb_drv ? tb_d : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (dq[g]);
    end

    sram_responder #(.DEPTH_LOG2(DL), .READ_LAT(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
    );

    // reference: word array with per-byte known flags, plus a log of what each edge sampled
    logic [15:0] mm [4096];
    logic [1:0]  kn [4096];
    bit          hv [2048];
    logic [15:0] hd [2048];
    logic [1:0]  hk [2048];
    logic        hub [2048], hlb [2048];
    int          edge_n = 0, last_rst = 0, rdc = 0, wrc = 0;
    bit          pe = 0;

    typedef struct {
        string       name;
        logic [15:0] dq, mask;
        int          rc, wc;
        bit          pe;
    } exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0;

    task automatic chk(input string nm, input bit ok, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk({m.name, " dq"}, ((dq ^ m.dq) & m.mask) == 16'h0, dq, m.dq);
            chk({m.name, " rd_count"}, rd_count == CW'(m.rc), 16'(rd_count), 16'(m.rc));
            chk({m.name, " wr_count"}, wr_count == CW'(m.wc), 16'(wr_count), 16'(m.wc));
            chk({m.name, " proto_err"}, proto_err == m.pe, 16'(proto_err), 16'(m.pe));
        end
    end

    task automatic cyc(input string nm, input logic r, ce, we, oe, ub, lb,
                       input logic [17:0] a, input logic [15:0] d);
        exp_t e;
        int src;
        logic rdn, wrn, drv;
        logic [11:0] ia;
        rst = r; ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb;
        addr = a; tb_d = d; tb_drv = !we;
        rdn = !ce && we && !oe;
        wrn = !ce && !we;
        src = edge_n - L + 1;
        drv = r && rdn && src > last_rst && hv[src];
        e.name = nm; e.rc = rdc; e.wc = wrc; e.pe = pe;
        e.dq = 16'hFFFF; e.mask = 16'hFFFF;
        if (!we) e.dq = d;
        else begin
            if (drv && !hub[src]) begin
                e.dq[15:8] = hd[src][15:8];
                e.mask[15:8] = hk[src][1] ? 8'hFF : 8'h00;
            end
            if (drv && !hlb[src]) begin
                e.dq[7:0] = hd[src][7:0];
                e.mask[7:0] = hk[src][0] ? 8'hFF : 8'h00;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        edge_n++;
        ia = a[11:0];
        hv[edge_n] = rdn; hd[edge_n] = mm[ia]; hk[edge_n] = kn[ia];
        hub[edge_n] = ub; hlb[edge_n] = lb;
        if (!r) begin
            last_rst = edge_n; rdc = 0; wrc = 0; pe = 0;
        end else begin
            if (rdn) rdc = (rdc < 15) ? rdc + 1 : 15;
            if (wrn) wrc = (wrc < 15) ? wrc + 1 : 15;
            if (!ce && !we && !oe) pe = 1;
        end
        if (wrn && !ub) begin mm[ia][15:8] = d[15:8]; kn[ia][1] = 1; end
        if (wrn && !lb) begin mm[ia][7:0] = d[7:0]; kn[ia][0] = 1; end
        #1;
    endtask

    task automatic wr(input string nm, input logic [17:0] a, input logic [15:0] d, input logic ub, lb);
        cyc(nm, 1, 0, 0, 1, ub, lb, a, d);
    endtask

    task automatic rd(input string nm, input logic [17:0] a, input logic ub, lb, input int n);
        for (int i = 0; i < n; i++) cyc(nm, 1, 0, 1, 0, ub, lb, a, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) kn[i] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        edge_n = 2; last_rst = 2;

        wr("wr_a5c3", 18'h00010, 16'hA5C3, 0, 0);
        rd("rd_a5c3", 18'h00010, 0, 0, 3);
        cyc("idle", 1, 1, 1, 1, 1, 1, 18'h0, 16'h0);

        wr("wr_1234", 18'h5, 16'h1234, 0, 0);
        wr("wr_ff00_ub", 18'h5, 16'hFF00, 0, 1);
        rd("rd_ff34", 18'h5, 0, 0, 3);
        rd("rd_lb_only", 18'h5, 1, 0, 3);

        wr("wr_alias", 18'h01003, 16'hBEEF, 0, 0);
        rd("rd_alias", 18'h00003, 0, 0, 3);

        cyc("proto", 1, 0, 0, 0, 0, 0, 18'h7, 16'h0F0F);
        cyc("post_proto", 1, 1, 1, 1, 1, 1, 18'h0, 16'h0);
        rd("rd_proto_mem", 18'h7, 0, 0, 3);

        rd("rd_pre_rst", 18'h00010, 0, 0, 3);
        cyc("rst_mid", 0, 0, 1, 0, 0, 0, 18'h00010, 16'h0);
        rd("rd_post_rst", 18'h00010, 0, 0, 3);

        for (int i = 0; i < 20; i++) wr("sat", 18'h20, 16'(i), 0, 0);
        rd("rd_sat", 18'h20, 0, 0, 20);

        for (int i = 0; i < 500; i++)
            cyc("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                {6'($urandom), 8'h00, 4'($urandom)}, 16'($urandom));

        cyc("end", 1, 1, 1, 1, 1, 1, 18'h0, 16'h0);
        @(negedge clk);
        #1;
        chk("drain", sb.size() == 0, 16'(sb.size()), 16'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Clocked, synthesizable model of the external 16-bit asynchronous SRAM, sitting on the far side of the SRAM_* pin bundle that the MEM-stage memory controller drives.
- Used in simulation and on-FPGA loopback builds in place of the physical chip.
- Services word/byte writes and reads with a configurable read latency, so that the controller's wait-state and ready logic can be exercised.
- Also reports access counters and a sticky protocol-violation flag.

Parameters:
- DEPTH_LOG2, 12: number of implemented address bits. Storage is 2^DEPTH_LOG2 x 16 bits. SRAM_ADDR bits above this are ignored, so addresses alias.
- READ_LAT, 2: cycles from sampling a read request to driving its data. Legal range 1..4.
- CNT_W, 16: width of the access counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- SRAM_DQ  inout  16  bidirectional data bus. The responder drives it only as described under Behaviour; otherwise it is high-Z.
- SRAM_ADDR  in  18  word address.
- SRAM_UB_N  in  1  upper byte enable (bits 15:8), active-low.
- SRAM_LB_N  in  1  lower byte enable (bits 7:0), active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- rd_count  out  CNT_W  number of read samples accepted; saturating.
- wr_count  out  CNT_W  number of write samples accepted; saturating.
- proto_err  out  1  sticky flag: WE_N and OE_N were both low while CE_N was low.

Behaviour:
- Reset
  - Sampled at the rising edge while rst=0.
  - Clears the read pipeline valid bits, rd_count, wr_count and proto_err to 0.
  - Memory contents are not cleared.
  - While rst=0, SRAM_DQ is combinationally forced to high-Z.
- Decoded conditions, evaluated each cycle from the pins
  - wr_c = !CE_N & !WE_N
  - rd_c = !CE_N & WE_N & !OE_N
  - WE_N low has priority: OE_N is ignored during a write.
- Write
  - Happens at each rising edge with wr_c=1.
  - mem[ADDR[DEPTH_LOG2-1:0]] byte 1 <= DQ[15:8] if UB_N=0.
  - mem[ADDR[DEPTH_LOG2-1:0]] byte 0 <= DQ[7:0] if LB_N=0.
  - wr_count increments by 1, saturating at all-ones.
  - With UB_N=LB_N=1 the write is still counted but memory is unchanged.
- Read pipeline
  - Each rising edge shifts a READ_LAT-deep pipeline of {valid, data, ub_n, lb_n}.
  - Stage 0 captures valid=rd_c, data=mem[addr], and the byte enables.
  - rd_count increments on each edge where rd_c=1, saturating.
  - Data is taken from the array at the sampling edge; a write can never occur on the same edge because WE_N has priority.
- DQ drive
  - DQ[15:8] is driven with the last stage's data when rd_c=1 AND last-stage valid=1 AND last-stage ub_n=0.
  - DQ[7:0] is driven under the same condition using lb_n.
  - Any byte lane not meeting its condition is high-Z.
- Read timing
  - A read held with a stable address from edge N returns valid data after edge N+READ_LAT-1. With READ_LAT=1, data appears in the cycle following edge N.
  - Changing the address mid-read yields the data for the address sampled READ_LAT edges earlier.
  - Deasserting OE_N or CE_N releases DQ combinationally in the same cycle.
- Read-after-write to the same address in the next cycle returns the newly written data.
- proto_err is set on any edge where !CE_N & !WE_N & !OE_N, and is cleared only by reset.
- CE_N high: no access, no count, DQ high-Z, and the pipeline shifts in valid=0.

Test Plan:
- Write then read, full word, READ_LAT=2:
  - Stimulus: write 16'hA5C3 to ADDR 18'h00010 with UB_N=LB_N=0; then hold a read at the same address.
  - Response: DQ is Z after the first read edge and reads 16'hA5C3 after the second; rd_count=2, wr_count=1.
- Byte writes:
  - Stimulus: word 16'h1234 at ADDR 5; write 16'hFF00 with LB_N=1; then read.
  - Response: 16'hFF34.
  - Follow-up: a read with UB_N=1 leaves DQ[15:8]=Z while DQ[7:0]=8'h34.
- Aliasing:
  - Stimulus: write 16'hBEEF to ADDR 18'h01003 with DEPTH_LOG2=12.
  - Response: a read of ADDR 18'h00003 returns 16'hBEEF.
- Protocol error and priority:
  - Stimulus: CE_N=0, WE_N=0, OE_N=0 for one edge with DQ driven 16'h0F0F by the bench.
  - Response: proto_err=1 and stays 1; memory is written; the responder never drives DQ during that cycle.
- Reset mid-read:
  - Stimulus: during a held read with DQ driving 16'hA5C3, assert rst=0 for one edge.
  - Response: DQ is Z immediately; the counters and proto_err are 0 after the edge; once rst=1, a re-read returns 16'hA5C3 after READ_LAT edges.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 consecutive write edges.
  - Response: wr_count holds at 4'hF.
